// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the ctrl/jtag memory port arbiter
package mem_arb_pkg;

  localparam int MEM_ADDR_BITS = 16;
  localparam int MEM_DATA_BITS = 8;
  localparam int RD_LAT        = 2;

  typedef enum logic {
    PORT_CTRL = 1'b0,
    PORT_JTAG = 1'b1
  } port_id_t;

  typedef struct packed {
    logic                     we;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [MEM_DATA_BITS-1:0] wdata;
  } mem_req_t;

  // One entry per in-flight read; oob forces the returned data to zero.
  typedef struct packed {
    logic     valid;
    port_id_t owner;
    logic     oob;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side memory port: valid/grant request plus rvalid-tagged read return
interface mem_port_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int DATA_BITS = MEM_DATA_BITS
);
  logic                 req;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [DATA_BITS-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - combinational grant (ctrl priority when busy, else round-robin) and rr_last register
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic aclr_n,
  input  logic ctrl_req,
  input  logic jtag_req,
  input  logic ctrl_busy,
  output logic ctrl_gnt,
  output logic jtag_gnt
);
  port_id_t rr_last;

  always_comb begin
    ctrl_gnt = ctrl_req && (ctrl_busy || !jtag_req || rr_last == PORT_JTAG);
    jtag_gnt = jtag_req && !ctrl_gnt;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      rr_last <= PORT_JTAG;
    end else if (ctrl_gnt) begin
      rr_last <= PORT_CTRL;
    end else if (jtag_gnt) begin
      rr_last <= PORT_JTAG;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared SRAM responder for ctrl and jtag ports, registered issue, 2-cycle read return
// Optional out-of-range trapping with sticky oob_err: define MEM_ARB_RANGE_CHECK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS     = MEM_ADDR_BITS,
  parameter int DATA_BITS     = MEM_DATA_BITS,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     aclr_n,
  mem_port_if.slave                ctrl,
  mem_port_if.slave                jtag,
  input  logic                     ctrl_busy,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0]     ram_wdata,
  input  logic [DATA_BITS-1:0]     ram_rdata,
  output logic                     oob_err
);
  logic                 ctrl_gnt;
  logic                 jtag_gnt;
  logic                 accept;
  logic                 req_oob;
  port_id_t             sel_owner;
  mem_req_t             sel;
  rd_tag_t              tag_q [RD_LAT];
  logic                 ctrl_rvalid;
  logic                 jtag_rvalid;
  logic [DATA_BITS-1:0] rdata_eff;
  logic [DATA_BITS-1:0] ctrl_rdata_q;
  logic [DATA_BITS-1:0] jtag_rdata_q;

  mem_arb_rr u_rr (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .ctrl_req  (ctrl.req),
    .jtag_req  (jtag.req),
    .ctrl_busy (ctrl_busy),
    .ctrl_gnt  (ctrl_gnt),
    .jtag_gnt  (jtag_gnt)
  );

  assign ctrl.gnt = ctrl_gnt;
  assign jtag.gnt = jtag_gnt;
  assign accept   = ctrl_gnt | jtag_gnt;

  always_comb begin
    sel_owner = PORT_JTAG;
    sel       = '{we: jtag.we, addr: jtag.addr, wdata: jtag.wdata};
    if (ctrl_gnt) begin
      sel_owner = PORT_CTRL;
      sel       = '{we: ctrl.we, addr: ctrl.addr, wdata: ctrl.wdata};
    end
  end

`ifdef MEM_ARB_RANGE_CHECK_EN
  assign req_oob = |sel.addr[ADDR_BITS-1:RAM_ADDR_BITS];

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      oob_err <= 1'b0;
    end else if (accept && req_oob) begin
      oob_err <= 1'b1;
    end
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^sel.addr[ADDR_BITS-1:RAM_ADDR_BITS];
  assign req_oob        = 1'b0;
  assign oob_err        = 1'b0;
`endif

  // Trapped requests leave the SRAM address/data untouched and never write.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ram_we <= accept && sel.we && !req_oob;
      if (accept && !req_oob) begin
        ram_addr  <= sel.addr[RAM_ADDR_BITS-1:0];
        ram_wdata <= sel.wdata;
      end
      tag_q[0] <= '{valid: accept && !sel.we, owner: sel_owner, oob: req_oob};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign ctrl_rvalid = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].owner == PORT_CTRL);
  assign jtag_rvalid = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].owner == PORT_JTAG);
  assign rdata_eff   = tag_q[RD_LAT-1].oob ? '0 : ram_rdata;

  // SRAM data only arrives in the rvalid cycle, so it is passed through then and held afterwards.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ctrl_rdata_q <= '0;
      jtag_rdata_q <= '0;
    end else begin
      if (ctrl_rvalid) begin
        ctrl_rdata_q <= rdata_eff;
      end
      if (jtag_rvalid) begin
        jtag_rdata_q <= rdata_eff;
      end
    end
  end

  assign ctrl.rvalid = ctrl_rvalid;
  assign jtag.rvalid = jtag_rvalid;
  assign ctrl.rdata  = ctrl_rvalid ? rdata_eff : ctrl_rdata_q;
  assign jtag.rdata  = jtag_rvalid ? rdata_eff : jtag_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AB    = 16;
  localparam int DB    = 8;
  localparam int RB    = 8;
  localparam int NRAND = 3000;

  typedef struct {
    int            due;
    bit            jtag;
    logic [DB-1:0] data;
  } rsp_t;

  logic          clk       = 1'b0;
  logic          aclr_n    = 1'b0;
  logic          ctrl_busy = 1'b0;
  logic          ram_we;
  logic [RB-1:0] ram_addr;
  logic [DB-1:0] ram_wdata;
  logic [DB-1:0] ram_rdata = '0;
  logic          oob_err;
  logic [DB-1:0] sram [256] = '{default: '0};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit            m_rr_jtag;
  logic [DB-1:0] m_mem [256] = '{default: '0};
  rsp_t          m_rsp [$];
  logic [DB-1:0] m_hold_c;
  logic [DB-1:0] m_hold_j;
  bit            m_oob;
  bit            m_ram_we;
  logic [RB-1:0] m_ram_addr;
  bit            last_gc;
  bit            last_gj;

  always #5 clk = ~clk;

  mem_port_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ctrl_if ();
  mem_port_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) jtag_if ();

  mem_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .RAM_ADDR_BITS(RB)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .ctrl      (ctrl_if),
    .jtag      (jtag_if),
    .ctrl_busy (ctrl_busy),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .oob_err   (oob_err)
  );

  // Write-first synchronous SRAM
  always @(posedge clk) begin
    if (ram_we) begin
      sram[ram_addr] <= ram_wdata;
      ram_rdata      <= ram_wdata;
    end else begin
      ram_rdata <= sram[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_c(input logic r, input logic w, input logic [AB-1:0] a, input logic [DB-1:0] d);
    ctrl_if.req = r; ctrl_if.we = w; ctrl_if.addr = a; ctrl_if.wdata = d;
  endtask

  task automatic set_j(input logic r, input logic w, input logic [AB-1:0] a, input logic [DB-1:0] d);
    jtag_if.req = r; jtag_if.we = w; jtag_if.addr = a; jtag_if.wdata = d;
  endtask

  function automatic logic [AB-1:0] rand_addr();
    logic [7:0] hi;
    hi = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    return {hi, 8'($urandom_range(0, 15))};
  endfunction

  task automatic model_reset();
    m_rsp.delete();
    m_rr_jtag  = 1'b1;
    m_hold_c   = '0;
    m_hold_j   = '0;
    m_oob      = 1'b0;
    m_ram_we   = 1'b0;
    m_ram_addr = '0;
    last_gc    = 1'b0;
    last_gj    = 1'b0;
  endtask

  // One clock: check everything visible this cycle, then advance the model by this cycle's acceptance.
  task automatic tick();
    bit            win_c, win_j, oob, we, exp_cv, exp_jv;
    logic [AB-1:0] a;
    logic [DB-1:0] wd, rd;
    rsp_t          r;
    @(negedge clk);
    win_c = 1'b0;
    win_j = 1'b0;
    if (ctrl_if.req && jtag_if.req) begin
      if (ctrl_busy || m_rr_jtag) win_c = 1'b1;
      else win_j = 1'b1;
    end else begin
      win_c = ctrl_if.req;
      win_j = jtag_if.req;
    end
    check_eq("ctrl_gnt", ctrl_if.gnt, win_c);
    check_eq("jtag_gnt", jtag_if.gnt, win_j);
    exp_cv = 1'b0;
    exp_jv = 1'b0;
    if (m_rsp.size() > 0 && m_rsp[0].due == cyc) begin
      r = m_rsp.pop_front();
      if (r.jtag) begin
        exp_jv   = 1'b1;
        m_hold_j = r.data;
      end else begin
        exp_cv   = 1'b1;
        m_hold_c = r.data;
      end
    end
    check_eq("ctrl_rvalid", ctrl_if.rvalid, exp_cv);
    check_eq("jtag_rvalid", jtag_if.rvalid, exp_jv);
    check_eq("ctrl_rdata", ctrl_if.rdata, m_hold_c);
    check_eq("jtag_rdata", jtag_if.rdata, m_hold_j);
    check_eq("ram_we", ram_we, m_ram_we);
    check_eq("ram_addr", ram_addr, m_ram_addr);
    check_eq("oob_err", oob_err, m_oob);
    m_ram_we = 1'b0;
    if (win_c || win_j) begin
      a  = win_c ? ctrl_if.addr : jtag_if.addr;
      we = win_c ? ctrl_if.we : jtag_if.we;
      wd = win_c ? ctrl_if.wdata : jtag_if.wdata;
`ifdef MEM_ARB_RANGE_CHECK_EN
      oob = (a >> RB) != 0;
`else
      oob = 1'b0;
`endif
      m_rr_jtag = win_j;
      if (!oob) begin
        m_ram_we   = we;
        m_ram_addr = a[RB-1:0];
        if (we) m_mem[a[RB-1:0]] = wd;
      end
      if (oob) m_oob = 1'b1;
      if (!we) begin
        rd = oob ? '0 : m_mem[a[RB-1:0]];
        m_rsp.push_back('{due: cyc + RD_LAT, jtag: win_j, data: rd});
      end
    end
    last_gc = win_c;
    last_gj = win_j;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    aclr_n    = 1'b0;
    ctrl_busy = 1'b0;
    set_c(0, 0, '0, '0);
    set_j(0, 0, '0, '0);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_ctrl_gnt", ctrl_if.gnt, 0);
      check_eq("rst_jtag_gnt", jtag_if.gnt, 0);
      check_eq("rst_ctrl_rvalid", ctrl_if.rvalid, 0);
      check_eq("rst_jtag_rvalid", jtag_if.rvalid, 0);
      check_eq("rst_ctrl_rdata", ctrl_if.rdata, 0);
      check_eq("rst_jtag_rdata", jtag_if.rdata, 0);
      check_eq("rst_ram_we", ram_we, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_ram_wdata", ram_wdata, 0);
      check_eq("rst_oob_err", oob_err, 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    aclr_n = 1'b1;
  endtask

  initial begin
    set_c(0, 0, '0, '0);
    set_j(0, 0, '0, '0);
    model_reset();
    #1;
    apply_reset();

    // jtag write then read back
    set_j(1, 1, 16'h0010, 8'h2A); tick();
    set_j(1, 0, 16'h0010, 8'h00); tick();
    set_j(0, 0, '0, '0);
    repeat (3) tick();

    // both ports reading, round-robin
    set_c(1, 0, 16'h0003, 8'h00);
    set_j(1, 0, 16'h0010, 8'h00);
    repeat (8) tick();
    set_c(0, 0, '0, '0);
    set_j(0, 0, '0, '0);
    repeat (3) tick();

    // ctrl strict priority while busy
    ctrl_busy = 1'b1;
    set_c(1, 0, 16'h0003, 8'h00);
    set_j(1, 0, 16'h0010, 8'h00);
    repeat (10) tick();
    set_c(0, 0, '0, '0);
    tick();
    set_j(0, 0, '0, '0);
    ctrl_busy = 1'b0;
    repeat (3) tick();

    // read-after-write on consecutive cycles
    set_c(1, 1, 16'h0003, 8'h55); tick();
    set_c(1, 0, 16'h0003, 8'h00); tick();
    set_c(0, 0, '0, '0);
    repeat (3) tick();

    // address truncation / range boundary
    set_c(1, 1, 16'h00FF, 8'hA5); tick();
    set_c(1, 1, 16'h0000, 8'h11); tick();
    set_c(1, 1, 16'h0001, 8'h22); tick();
    set_c(1, 0, 16'h00FF, 8'h00); tick();
    set_c(1, 0, 16'h0100, 8'h00); tick();
    set_c(1, 0, 16'h0101, 8'h00); tick();
    set_c(0, 0, '0, '0);
    repeat (3) tick();
`ifdef MEM_ARB_RANGE_CHECK_EN
    check_eq("oob_sticky", oob_err, 1);
`else
    check_eq("oob_sticky", oob_err, 0);
`endif

    // reset one cycle after a read is accepted
    set_c(1, 0, 16'h0003, 8'h00); tick();
    apply_reset();
    repeat (4) tick();

    // randomized traffic, requests held until granted
    for (int i = 0; i < NRAND; i++) begin
      if (!ctrl_if.req || last_gc)
        set_c(($urandom_range(0, 99) < 60), ($urandom_range(0, 2) == 0), rand_addr(), 8'($urandom));
      if (!jtag_if.req || last_gj)
        set_j(($urandom_range(0, 99) < 60), ($urandom_range(0, 2) == 0), rand_addr(), 8'($urandom));
      if ($urandom_range(0, 7) == 0) ctrl_busy = ~ctrl_busy;
      tick();
    end
    set_c(0, 0, '0, '0);
    set_j(0, 0, '0, '0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Memory-side responder shared by the interpolation control unit (ctrl port) and the JTAG front-end (jtag port).
- Accepts pipelined read/write requests through valid/grant handshakes and arbitrates between the two ports.
- Drives a synchronous single-port SRAM and returns read data to the owning port, tagged by an rvalid strobe.
- Replaces the combinational busy-based mux in the top level with a registered, handshake-correct memory responder.

Parameters:
- ADDR_BITS, 16, requester address width (control unit emits 16-bit addresses).
- DATA_BITS, 8, pixel/data width.
- RAM_ADDR_BITS, 8, physical SRAM address width; requester addresses are truncated to this width.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- aclr_n  in  1  asynchronous active-low reset.
- ctrl_req  in  1  ctrl port request valid; held until granted.
- ctrl_we  in  1  1 = write, 0 = read.
- ctrl_addr  in  ADDR_BITS  ctrl address.
- ctrl_wdata  in  DATA_BITS  ctrl write data.
- ctrl_gnt  out  1  request accepted this cycle (combinational).
- ctrl_rvalid  out  1  read data valid for the ctrl port.
- ctrl_rdata  out  DATA_BITS  read data.
- ctrl_busy  in  1  control unit processing; gives ctrl strict priority.
- jtag_req / jtag_we / jtag_addr / jtag_wdata / jtag_gnt / jtag_rvalid / jtag_rdata  —  same directions, widths and meanings as the ctrl port.
- ram_we  out  1  SRAM write enable (registered).
- ram_addr  out  RAM_ADDR_BITS  SRAM address (registered).
- ram_wdata  out  DATA_BITS  SRAM write data (registered).
- ram_rdata  in  DATA_BITS  SRAM read data, valid one cycle after ram_addr is presented.
- oob_err  out  1  sticky out-of-range flag; see Optional Feature.

Behaviour:
- Reset: all outputs 0, rr_last = JTAG, read-tag pipeline cleared; in-flight reads are discarded and no rvalid is issued after reset.
- Acceptance:
  - A request is accepted in cycle N when req && gnt.
  - At most one acceptance per cycle across both ports; gnt is never asserted without req.
- Arbitration (gnt is a combinational function of the req inputs, ctrl_busy and rr_last):
  - ctrl_busy = 1: ctrl strict priority; jtag_gnt = 0 whenever ctrl_req = 1.
  - ctrl_busy = 0: round-robin; when both ports request, grant the port not in rr_last. rr_last updates only on acceptance.
  - Single requester: granted immediately, no bubble.
- Issue stage, cycle N+1:
  - ram_addr = addr[RAM_ADDR_BITS-1:0], ram_we = we, ram_wdata = wdata.
  - With no acceptance, ram_we = 0 and ram_addr holds its previous value.
- Read return:
  - A 2-stage tag pipeline (valid, owner) records each accepted read; rvalid is asserted for exactly one cycle at N+2, with rdata = ram_rdata, on the owner port only.
  - rdata holds its last value when rvalid = 0.
  - Back-to-back reads return at one per cycle, in acceptance order.
- Writes produce no response; the SRAM is updated at the N+1 edge.
- Read-after-write to the same address accepted in cycle N+1 returns the new data (SRAM write-first ordering).
- Simultaneous ctrl_busy rising with a pending jtag_req: ctrl wins from that same cycle. A jtag read already accepted still returns its rvalid.

Optional Feature:
- Macro: MEM_ARB_RANGE_CHECK_EN.
- Defined:
  - Any accepted request with addr[ADDR_BITS-1:RAM_ADDR_BITS] != 0 is not forwarded to the SRAM (ram_we = 0).
  - An out-of-range read still returns rvalid at N+2 with rdata = 0.
  - oob_err sets at N+1 and is cleared only by reset.
- Undefined: addresses are silently truncated and oob_err is tied to 0.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {PORT_CTRL, PORT_JTAG} port_id_t
  - struct mem_req_t {we, addr, wdata}
  - localparam RD_LAT = 2
- One sub-module, mem_arb_rr: the combinational round-robin/priority grant logic plus the rr_last register.

Test Plan:
- Reset, then jtag write 0x2A to addr 0x0010, then jtag read 0x0010 → jtag_gnt same cycle as req; jtag_rvalid exactly 2 cycles after read acceptance with 0x2A; ctrl_rvalid stays 0.
- ctrl_busy = 0, both ports request reads continuously → grants alternate ctrl/jtag every cycle, starting with ctrl (rr_last = JTAG after reset); each rvalid lands on its owner port.
- ctrl_busy = 1, both ports request → jtag_gnt = 0 for 10 cycles; after ctrl_req drops, jtag is granted the same cycle.
- ctrl write 0x55 to 0x0003 in cycle N, ctrl read 0x0003 in N+1 → ctrl_rvalid at N+3 with 0x55.
- ctrl reads 0x00FF, 0x0100, 0x0101 → without the macro: data from SRAM addresses 0xFF, 0x00, 0x01 and oob_err = 0. With MEM_ARB_RANGE_CHECK_EN: 0x0100 and 0x0101 return 0x00 and oob_err = 1 and sticky from the 0x0100 read onward.
- aclr_n asserted one cycle after a read is accepted → no rvalid is ever issued for that read; all outputs 0 while reset is held.
